layer_output_serializer: RTL and testbench
==========================================

Name: layer_output_serializer

Overview:
- Sits directly downstream of one layer's bank of NUM_NEURONS neurons.
- Captures each neuron's activation output when that neuron pulses outvalid.
- Once every neuron in the layer has reported, streams the activations one word per cycle, neuron 0 first, as the myinput/myinputValid stream for the next layer's neurons.
- Flags protocol violations (data arriving while busy, duplicate reports) with a sticky overrun bit.

Parameters:
- NUM_NEURONS, 30, neurons in the producing layer; number of words per output frame.
- DATA_WIDTH, 16, width of each activation word.
- IDX_WIDTH, $clog2(NUM_NEURONS), width of the word index counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- neuron_out  in  NUM_NEURONS*DATA_WIDTH  packed activations; neuron i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- neuron_valid  in  NUM_NEURONS  per-neuron outvalid; single-cycle pulses.
- out_data  out  DATA_WIDTH  serialized activation, registered.
- out_valid  out  1  out_data valid, registered; feeds next-layer myinputValid.
- frame_done  out  1  one-cycle pulse coincident with the last word of a frame.
- busy  out  1  high while in SHIFT.
- overrun  out  1  sticky error flag; cleared only by rst.

Behaviour:
- Reset (synchronous, active-high):
  - State goes to COLLECT, collected mask and index go to 0.
  - out_valid, frame_done, busy and overrun go to 0; out_data goes to 0.
  - Holding registers are not required to reset.
  - Asserting rst mid-frame aborts the frame: out_valid is 0 from the cycle after the rst edge, and partial captures are discarded.
- State COLLECT:
  - For each i where neuron_valid[i]=1 and mask[i]=0: hold[i] <= neuron_out slice i, and mask[i] <= 1.
  - For each i where neuron_valid[i]=1 and mask[i]=1 (duplicate): hold[i] is overwritten with the new value and overrun <= 1.
  - Any number of bits may be set in the same cycle; all set bits are captured together.
  - The frame completes when (mask | neuron_valid) is all-ones, evaluated in the sampling cycle T. At the edge ending T: state <= SHIFT, idx <= 0, mask <= 0, busy <= 1.
- State SHIFT:
  - On each edge: out_data <= hold[idx], out_valid <= 1, idx <= idx+1.
  - When idx = NUM_NEURONS-1: frame_done <= 1 with that word, and state <= COLLECT.
  - On the following edge: out_valid <= 0, frame_done <= 0, busy <= 0.
- Latency: with all valids sampled in cycle T, word 0 is visible in cycle T+2 and word N-1 in cycle T+N+1. out_valid stays high for exactly NUM_NEURONS contiguous cycles, with no gaps.
- neuron_valid asserted in SHIFT:
  - The data is not captured and overrun <= 1.
  - The frame in progress continues unaffected.
  - The mask remains 0.
- neuron_valid in the cycle the state returns to COLLECT (the frame_done cycle, state already COLLECT) is captured normally. A back-to-back frame is therefore legal.
- idx never exceeds NUM_NEURONS-1, so there is no wrap-around beyond the frame.
- The outputs never present X after reset.
- Arithmetic:
  - No arithmetic is performed on the data; words pass through bit-exact.
  - The signed interpretation of the words is the consumer's concern.

Test Plan:
- Simultaneous capture: NUM_NEURONS=4, all neuron_valid=4'b1111 in cycle T with words 0x0001, 0x0002, 0x7FFF, 0x8000.
  - Required: out_valid high in cycles T+2..T+5 carrying 0x0001, 0x0002, 0x7FFF, 0x8000 in order.
  - Required: frame_done only in T+5; busy high T+1..T+5; overrun=0.
- Staggered capture: valids for neurons 2, 0, 3, 1 in cycles 10, 12, 15, 20 with values 0xC, 0xA, 0xD, 0xB.
  - Required: out words 0xA, 0xB, 0xC, 0xD in cycles 22..25.
- Busy violation: during SHIFT, pulse neuron_valid[1] with 0x1234.
  - Required: overrun=1 from the next cycle; the current frame's words are unchanged.
  - Required: the next COLLECT starts with an empty mask (0x1234 is never output).
- Duplicate report: pulse neuron 0 with 0x0011, then neuron 0 again with 0x0022, then neurons 1..3.
  - Required: overrun=1; first output word is 0x0022.
- Back-to-back frames: a second all-ones valid in the frame_done cycle of frame 1.
  - Required: frame 2 words begin 2 cycles later; out_valid has a 1-cycle gap between the frames; overrun=0.
- Reset mid-frame: assert rst in the cycle word 1 is output.
  - Required: out_valid=0, busy=0, overrun=0 the next cycle.
  - Required: a subsequent full frame serializes correctly.

Source files
------------

// File: rtl/layer_output_serializer_if.sv
`default_nettype none
// ============================================================================
// Module      : layer_output_serializer_if
// Description : Neuron-bank capture inputs and serialized activation stream.
// Revision    : 1.0 - initial release
// ============================================================================
interface layer_output_serializer_if #(
    parameter int NUM_NEURONS = 30,
    parameter int DATA_WIDTH  = 16
);
    logic [NUM_NEURONS*DATA_WIDTH-1:0] neuron_out;
    logic [NUM_NEURONS-1:0]            neuron_valid;
    logic [DATA_WIDTH-1:0]             out_data;
    logic                              out_valid;
    logic                              frame_done;
    logic                              busy;
    logic                              overrun;

    modport master (
        output neuron_out,
        output neuron_valid,
        input  out_data,
        input  out_valid,
        input  frame_done,
        input  busy,
        input  overrun
    );

    modport slave (
        input  neuron_out,
        input  neuron_valid,
        output out_data,
        output out_valid,
        output frame_done,
        output busy,
        output overrun
    );
endinterface
`default_nettype wire

// File: rtl/layer_output_serializer.sv
`default_nettype none
// ============================================================================
// Module      : layer_output_serializer
// Description : Collects one activation per neuron, then streams them in order.
// Revision    : 1.0 - initial release
// ============================================================================
module layer_output_serializer #(
    parameter int NUM_NEURONS = 30,
    parameter int DATA_WIDTH  = 16,
    parameter int IDX_WIDTH   = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    layer_output_serializer_if.slave  bus_io
);

    localparam logic [0:0]             c_ST_COLLECT = 1'b0;
    localparam logic [0:0]             c_ST_SHIFT   = 1'b1;
    localparam logic [IDX_WIDTH-1:0]   c_IDX_LAST   = IDX_WIDTH'(NUM_NEURONS - 1);
    localparam logic [NUM_NEURONS-1:0] c_ALL_ONES   = '1;

    logic [0:0]             state_q, state_d;
    logic [NUM_NEURONS-1:0] mask_q, mask_d;
    logic [IDX_WIDTH-1:0]   idx_q, idx_d;
    logic [DATA_WIDTH-1:0]  out_data_q, out_data_d;
    logic                   out_valid_q, out_valid_d;
    logic                   frame_done_q, frame_done_d;
    logic                   busy_q, busy_d;
    logic                   overrun_q, overrun_d;
    logic [DATA_WIDTH-1:0]  hold_q [NUM_NEURONS];
    logic                   frame_complete;

    // Completion counts neurons reporting in this very cycle.
    assign frame_complete = (state_q == c_ST_COLLECT) &&
                            ((mask_q | bus_io.neuron_valid) == c_ALL_ONES);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= c_ST_COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_ST_COLLECT: if (frame_complete)      state_d = c_ST_SHIFT;
            c_ST_SHIFT:   if (idx_q == c_IDX_LAST) state_d = c_ST_COLLECT;
            default:                               state_d = c_ST_COLLECT;
        endcase
    end

    always_comb begin
        mask_d       = mask_q;
        idx_d        = idx_q;
        out_data_d   = out_data_q;
        out_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        busy_d       = busy_q;
        overrun_d    = overrun_q;
        case (state_q)
            c_ST_COLLECT: begin
                mask_d = mask_q | bus_io.neuron_valid;
                if (|(bus_io.neuron_valid & mask_q)) overrun_d = 1'b1;
                // busy spans the frame_done cycle, then drops unless a new frame starts
                if (frame_done_q) busy_d = 1'b0;
                if (frame_complete) begin
                    mask_d = '0;
                    idx_d  = '0;
                    busy_d = 1'b1;
                end
            end
            c_ST_SHIFT: begin
                mask_d       = '0;
                out_data_d   = hold_q[idx_q];
                out_valid_d  = 1'b1;
                frame_done_d = (idx_q == c_IDX_LAST);
                idx_d        = (idx_q == c_IDX_LAST) ? '0 : idx_q + IDX_WIDTH'(1);
                if (|bus_io.neuron_valid) overrun_d = 1'b1;
            end
            default: begin
                mask_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q       <= '0;
            idx_q        <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            mask_q       <= mask_d;
            idx_q        <= idx_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
            overrun_q    <= overrun_d;
        end
    end

    // Holding words need no reset: they are only read after a full capture.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_NEURONS; i++) begin
            if ((state_q == c_ST_COLLECT) && bus_io.neuron_valid[i]) begin
                hold_q[i] <= bus_io.neuron_out[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign bus_io.out_data   = out_data_q;
    assign bus_io.out_valid  = out_valid_q;
    assign bus_io.frame_done = frame_done_q;
    assign bus_io.busy       = busy_q;
    assign bus_io.overrun    = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_layer_output_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_layer_output_serializer
// Description : Directed self-checking bench for a 4-neuron serializer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_layer_output_serializer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    layer_output_serializer_if #(.NUM_NEURONS(4), .DATA_WIDTH(16)) bus ();

    layer_output_serializer #(
        .NUM_NEURONS (4),
        .DATA_WIDTH  (16)
    ) u_dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Present valid/data for one sampling cycle; returns one cycle later.
    task automatic drive(input logic [3:0] v, input logic [63:0] d);
        bus.neuron_valid = v;
        bus.neuron_out   = d;
        tick();
        bus.neuron_valid = '0;
    endtask

    task automatic pulse(input int n, input logic [15:0] val);
        logic [63:0] d;
        d = '0;
        d[n*16 +: 16] = val;
        drive(4'(1 << n), d);
        tick();
    endtask

    task automatic words_check(input string tag, input logic [63:0] w);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk({tag, "_valid"}, 32'(bus.out_valid), 32'(1));
            chk({tag, "_word"}, 32'(bus.out_data), 32'(w[k*16 +: 16]));
            chk({tag, "_done"}, 32'(bus.frame_done), 32'(k == 3));
            chk({tag, "_busy"}, 32'(bus.busy), 32'(1));
        end
    endtask

    task automatic frame_check(input string tag, input logic [63:0] w);
        chk({tag, "_busy_start"}, 32'(bus.busy), 32'(1));
        chk({tag, "_valid_start"}, 32'(bus.out_valid), 32'(0));
        words_check(tag, w);
        tick();
        chk({tag, "_valid_end"}, 32'(bus.out_valid), 32'(0));
        chk({tag, "_busy_end"}, 32'(bus.busy), 32'(0));
        chk({tag, "_done_end"}, 32'(bus.frame_done), 32'(0));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        bus.neuron_valid = '0;
        bus.neuron_out   = '0;
        tick();
        tick();
        chk("rst_valid", 32'(bus.out_valid), 32'(0));
        chk("rst_done", 32'(bus.frame_done), 32'(0));
        chk("rst_busy", 32'(bus.busy), 32'(0));
        chk("rst_overrun", 32'(bus.overrun), 32'(0));
        chk("rst_data", 32'(bus.out_data), 32'(0));
        rst = 1'b0;
        tick();

        // Simultaneous capture including signed extremes
        drive(4'hF, {16'h8000, 16'h7FFF, 16'h0002, 16'h0001});
        frame_check("simul", {16'h8000, 16'h7FFF, 16'h0002, 16'h0001});
        chk("simul_overrun", 32'(bus.overrun), 32'(0));

        // Staggered capture, out of order
        pulse(2, 16'h000C);
        pulse(0, 16'h000A);
        tick();
        pulse(3, 16'h000D);
        chk("stag_not_busy", 32'(bus.busy), 32'(0));
        tick();
        tick();
        drive(4'b0010, {16'h0000, 16'h0000, 16'h000B, 16'h0000});
        frame_check("stag", {16'h000D, 16'h000C, 16'h000B, 16'h000A});

        // Report while busy is dropped and flagged
        drive(4'hF, {16'h4444, 16'h3333, 16'h2222, 16'h1111});
        chk("busyv_busy", 32'(bus.busy), 32'(1));
        tick();
        chk("busyv_w0", 32'(bus.out_data), 32'(16'h1111));
        drive(4'b0010, {16'h0000, 16'h0000, 16'h1234, 16'h0000});
        chk("busyv_overrun", 32'(bus.overrun), 32'(1));
        chk("busyv_w1", 32'(bus.out_data), 32'(16'h2222));
        tick();
        chk("busyv_w2", 32'(bus.out_data), 32'(16'h3333));
        tick();
        chk("busyv_w3", 32'(bus.out_data), 32'(16'h4444));
        chk("busyv_done", 32'(bus.frame_done), 32'(1));
        tick();
        chk("busyv_idle", 32'(bus.out_valid), 32'(0));
        pulse(0, 16'h00A0);
        pulse(2, 16'h00C0);
        pulse(3, 16'h00D0);
        chk("busyv_mask_empty", 32'(bus.busy), 32'(0));
        drive(4'b0010, {16'h0000, 16'h0000, 16'h0B0B, 16'h0000});
        frame_check("busyv_next", {16'h00D0, 16'h00C0, 16'h0B0B, 16'h00A0});
        chk("busyv_sticky", 32'(bus.overrun), 32'(1));
        do_reset();
        chk("busyv_rst_overrun", 32'(bus.overrun), 32'(0));

        // Duplicate report: latest value wins
        pulse(0, 16'h0011);
        chk("dup_first_ok", 32'(bus.overrun), 32'(0));
        pulse(0, 16'h0022);
        chk("dup_overrun", 32'(bus.overrun), 32'(1));
        drive(4'b1110, {16'h0333, 16'h0222, 16'h0111, 16'h0000});
        frame_check("dup", {16'h0333, 16'h0222, 16'h0111, 16'h0022});
        do_reset();

        // Back-to-back frames: new capture in the frame_done cycle
        drive(4'hF, {16'hA003, 16'hA002, 16'hA001, 16'hA000});
        chk("b2b_busy", 32'(bus.busy), 32'(1));
        words_check("b2b_f1", {16'hA003, 16'hA002, 16'hA001, 16'hA000});
        drive(4'hF, {16'hB003, 16'hB002, 16'hB001, 16'hB000});
        frame_check("b2b_f2", {16'hB003, 16'hB002, 16'hB001, 16'hB000});
        chk("b2b_overrun", 32'(bus.overrun), 32'(0));

        // Reset mid-frame
        drive(4'hF, {16'hC003, 16'hC002, 16'hC001, 16'hC000});
        tick();
        tick();
        chk("midrst_w1", 32'(bus.out_data), 32'(16'hC001));
        do_reset();
        chk("midrst_valid", 32'(bus.out_valid), 32'(0));
        chk("midrst_busy", 32'(bus.busy), 32'(0));
        chk("midrst_overrun", 32'(bus.overrun), 32'(0));

        // Partial captures are discarded by reset
        pulse(0, 16'hEE00);
        pulse(1, 16'hEE01);
        do_reset();
        pulse(2, 16'hD002);
        pulse(3, 16'hD003);
        chk("partial_discard", 32'(bus.busy), 32'(0));
        drive(4'b0011, {16'h0000, 16'h0000, 16'hD001, 16'hD000});
        frame_check("after_rst", {16'hD003, 16'hD002, 16'hD001, 16'hD000});
        chk("after_rst_overrun", 32'(bus.overrun), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
